array_loader: RTL and testbench

ARRAY_LOADER -- requirements
Module: array_loader

---
 rtl/array_loader.sv | 92 +++++++++
 tb/tb_array_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_loader.sv
// Collects a stream of data_width-bit elements into a parallel frame of data_cnt entries.
// Latency: an element accepted on edge N is visible on array after that edge (cycle N+1).
// Backpressure: in_ready is low for the whole HOLD period; the producer keeps its element until FILL.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last   element stream in (in_last ends a short frame)
//   array           data_cnt entries, index 0 = first element received; unused entries read 0
//   out_valid       frame complete and stable (HOLD)
//   out_ack         consumer releases the frame; only looked at while out_valid
//   count           number of elements in the current or held frame
module array_loader #(
  parameter int data_width = 16,
  parameter int data_cnt   = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [data_width-1:0]                in_data,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [data_cnt-1:0][data_width-1:0]  array,
  output logic                                 out_valid,
  input  logic                                 out_ack,
  output logic [$clog2(data_cnt+1)-1:0]        count
);

  localparam int IW = $clog2(data_cnt);
  localparam int CW = $clog2(data_cnt+1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                               state_q, state_d;
  logic [IW-1:0]                        idx_q, idx_d;
  logic [CW-1:0]                        count_q, count_d;
  logic [data_cnt-1:0][data_width-1:0]  array_q, array_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
      array_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      array_q <= array_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    array_d = array_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          array_d[idx_q] = in_data;
          count_d        = count_q + CW'(1);
          // The terminating transfer leaves idx at the last written slot so it can
          // never wrap onto entry 0; the ack clears it before the next frame.
          if ((idx_q == IW'(data_cnt-1)) || in_last) begin
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ack) begin
          state_d = FILL;
          idx_d   = '0;
          count_d = '0;
          array_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Ready depends on state only, never on in_valid.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign array     = array_q;
  assign count     = count_q;

endmodule

// File: tb/tb_array_loader.sv
module tb_array_loader;

  localparam int DW = 16;
  localparam int DC = 64;
  localparam int CW = $clog2(DC+1);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic [DW-1:0]           in_data = '0;
  logic                    in_last = 1'b0;
  logic                    in_ready;
  logic [DC-1:0][DW-1:0]   array;
  logic                    out_valid;
  logic                    out_ack = 1'b0;
  logic [CW-1:0]           count;

  int checks = 0;
  int errors = 0;

  // Reference model: the frame is just the ordered list of accepted elements.
  logic [DW-1:0] m_q[$];
  bit            m_hold = 1'b0;

  array_loader #(.data_width(DW), .data_cnt(DC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .array    (array),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .count    (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one clock; the model applies the rules to the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (m_hold) begin
        if (out_ack) begin
          m_hold = 1'b0;
          m_q.delete();
        end
      end else if (in_valid) begin
        m_q.push_back(in_data);
        if (m_q.size() == DC || in_last) m_hold = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [DC-1:0][DW-1:0] exp_array();
    logic [DC-1:0][DW-1:0] a;
    a = '0;
    foreach (m_q[i]) a[i] = m_q[i];
    return a;
  endfunction

  // Index of the first differing entry, or -1 when equal.
  function automatic int first_diff(logic [DC-1:0][DW-1:0] a, logic [DC-1:0][DW-1:0] e);
    for (int k = 0; k < DC; k++) if (a[k] !== e[k]) return k;
    return -1;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ack_frame();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [DC-1:0][DW-1:0] e;
    int d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    d = first_diff(array, '0);
    checks++;
    if (d >= 0) begin errors++; $display("FAIL reset_array idx %0d got %h exp 0", d, array[d]); end
    rst = 1'b0;
    m_q.delete();
    m_hold = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    // First edge after deassertion must already accept an element.
    send(16'h1234, 1'b1);
    checks++;
    if (count !== CW'(1) || out_valid !== 1'b1) begin
      errors++; $display("FAIL first_transfer count %0d out_valid %b exp 1 1", count, out_valid);
    end
    e = '0;
    e[0] = 16'h1234;
    d = first_diff(array, e);
    checks++;
    if (d >= 0) begin errors++; $display("FAIL first_transfer_array idx %0d got %h exp %h", d, array[d], e[d]); end
    ack_frame();
  endtask

  task automatic test_full_frame();
    int d;
    logic [DC-1:0][DW-1:0] e;
    in_valid = 1'b1;
    for (int k = 1; k <= DC; k++) begin
      in_data = DW'(k);
      step();
      checks++;
      if (count !== CW'(k) || out_valid !== (k == DC)) begin
        errors++; $display("FAIL full_progress k=%0d count %0d out_valid %b", k, count, out_valid);
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < DC; k++) e[k] = DW'(k + 1);
    d = first_diff(array, e);
    checks++;
    if (d >= 0) begin errors++; $display("FAIL full_array idx %0d got %h exp %h", d, array[d], e[d]); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    repeat (3) step();
    d = first_diff(array, e);
    checks++;
    if (d >= 0 || count !== CW'(DC) || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_hold_stable idx %0d count %0d out_valid %b", d, count, out_valid);
    end
    ack_frame();
    d = first_diff(array, '0);
    checks++;
    if (d >= 0 || count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_ack_clear idx %0d count %0d out_valid %b in_ready %b", d, count, out_valid, in_ready);
    end
  endtask

  task automatic test_short_frame();
    logic [DC-1:0][DW-1:0] e;
    int d;
    for (int i = 0; i < 5; i++) send(16'h3C00, i == 4);
    checks++;
    if (out_valid !== 1'b1 || count !== CW'(5)) begin
      errors++; $display("FAIL short_status out_valid %b count %0d exp 1 5", out_valid, count);
    end
    e = '0;
    for (int k = 0; k < 5; k++) e[k] = 16'h3C00;
    d = first_diff(array, e);
    checks++;
    if (d >= 0) begin errors++; $display("FAIL short_array idx %0d got %h exp %h", d, array[d], e[d]); end
    ack_frame();
  endtask

  task automatic test_backpressure();
    logic [DC-1:0][DW-1:0] e;
    int d;
    for (int i = 0; i < 3; i++) send(DW'($urandom), i == 2);
    e = exp_array();
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    for (int c = 0; c < 10; c++) begin
      step();
      d = first_diff(array, e);
      checks++;
      if (d >= 0 || count !== CW'(3) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold c=%0d idx %0d count %0d in_ready %b out_valid %b", c, d, count, in_ready, out_valid);
      end
    end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    d = first_diff(array, '0);
    checks++;
    if (d >= 0 || count !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ack_edge idx %0d count %0d in_ready %b exp -1 0 1", d, count, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (array[0] !== 16'hBEEF || count !== CW'(1)) begin
      errors++; $display("FAIL bp_landing array0 %h count %0d exp beef 1", array[0], count);
    end
    d = first_diff(array, exp_array());
    checks++;
    if (d >= 0) begin errors++; $display("FAIL bp_array idx %0d got %h", d, array[d]); end
    send(DW'($urandom), 1'b1);
    ack_frame();
  endtask

  task automatic test_gapped();
    int cyc = 0;
    int d;
    in_last = 1'b0;
    while (!m_hold && cyc < 2000) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = DW'($urandom);
      step();
      cyc++;
      checks++;
      if (count !== CW'(m_q.size()) || out_valid !== m_hold) begin
        errors++; $display("FAIL gap_count cyc=%0d count %0d exp %0d out_valid %b", cyc, count, m_q.size(), out_valid);
      end
    end
    in_valid = 1'b0;
    if (!m_hold) begin
      errors++; $display("FAIL gap_timeout frame never completed");
    end
    d = first_diff(array, exp_array());
    checks++;
    if (d >= 0) begin errors++; $display("FAIL gap_array idx %0d got %h", d, array[d]); end
    ack_frame();
  endtask

  task automatic test_reset_mid();
    int d;
    for (int i = 0; i < 30; i++) send(DW'($urandom), 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    d = first_diff(array, '0);
    checks++;
    if (d >= 0 || count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid idx %0d count %0d out_valid %b exp -1 0 0", d, count, out_valid);
    end
    m_q.delete();
    m_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DC; i++) send(DW'($urandom), 1'b0);
    d = first_diff(array, exp_array());
    checks++;
    if (d >= 0 || count !== CW'(DC) || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_reload idx %0d count %0d out_valid %b", d, count, out_valid);
    end
    // Reset while holding a frame must drop it for good.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_hold = 1'b0;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_hold out_valid %b count %0d in_ready %b exp 0 0 1", out_valid, count, in_ready);
    end
  endtask

  task automatic test_stray_ack();
    int d;
    for (int i = 0; i < 10; i++) send(DW'($urandom), 1'b0);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    d = first_diff(array, exp_array());
    checks++;
    if (d >= 0 || count !== CW'(10) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stray_ack idx %0d count %0d out_valid %b in_ready %b", d, count, out_valid, in_ready);
    end
    for (int i = 10; i < DC; i++) send(DW'($urandom), 1'b0);
    d = first_diff(array, exp_array());
    checks++;
    if (d >= 0 || count !== CW'(DC) || out_valid !== 1'b1) begin
      errors++; $display("FAIL stray_complete idx %0d count %0d out_valid %b", d, count, out_valid);
    end
    ack_frame();
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stray_ack_clear count %0d out_valid %b exp 0 0", count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    test_stray_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
